// File: rtl/mandelbrot_iter_engine_if.sv
// rtl/mandelbrot_iter_engine_if.sv - point-in / result-out handshake bundle for the iteration engine
interface mandelbrot_iter_engine_if #(
  parameter int WORD_LENGTH = 32,
  parameter int ITER_WIDTH  = 16
);
  logic                          in_valid;
  logic                          in_ready;
  logic signed [WORD_LENGTH-1:0] c_real;
  logic signed [WORD_LENGTH-1:0] c_imag;
  logic [10:0]                   x_in;
  logic [10:0]                   y_in;
  logic [ITER_WIDTH-1:0]         max_iter;
  logic                          out_valid;
  logic                          out_ready;
  logic [ITER_WIDTH-1:0]         iter_count;
  logic                          escaped;
  logic [10:0]                   x_out;
  logic [10:0]                   y_out;
  logic                          busy;

  modport master (
    output in_valid, c_real, c_imag, x_in, y_in, max_iter, out_ready,
    input  in_ready, out_valid, iter_count, escaped, x_out, y_out, busy
  );

  modport slave (
    input  in_valid, c_real, c_imag, x_in, y_in, max_iter, out_ready,
    output in_ready, out_valid, iter_count, escaped, x_out, y_out, busy
  );
endinterface

// File: rtl/mandelbrot_iter_engine.sv
// rtl/mandelbrot_iter_engine.sv - one z^2+c iteration per cycle until escape or the iteration limit
module mandelbrot_iter_engine #(
  parameter int WORD_LENGTH = 32,
  parameter int FRAC        = 28,
  parameter int ITER_WIDTH  = 16
) (
  input logic                      clk,
  input logic                      rst_n,
  mandelbrot_iter_engine_if.slave  eng
);
  localparam int W  = WORD_LENGTH;
  localparam int PW = 2 * WORD_LENGTH;
  // |z|^2 threshold of 4.0; equality does not count as escape
  localparam logic signed [PW:0] ESC_LIM = (PW+1)'(4) <<< FRAC;

  typedef enum logic [1:0] {S_IDLE, S_ITERATE, S_DONE} state_t;

  state_t                state_q, state_d;
  logic signed [W-1:0]   zr_q, zr_d, zi_q, zi_d;
  logic signed [W-1:0]   cr_q, cr_d, ci_q, ci_d;
  logic [ITER_WIDTH-1:0] n_q, n_d, limit_q, limit_d;
  logic [ITER_WIDTH-1:0] iter_count_q, iter_count_d;
  logic                  ovf_q, ovf_d, escaped_q, escaped_d;
  logic [10:0]           x_q, x_d, y_q, y_d;
  logic [10:0]           x_out_q, x_out_d, y_out_q, y_out_d;

  logic signed [PW-1:0]  rr_full, ii_full, ri_full;
  logic signed [PW-1:0]  rr, ii, ri;
  logic signed [PW:0]    mag;
  logic signed [PW+1:0]  zr_sum, zi_sum;
  logic [PW+2-W:0]       zr_top, zi_top;
  logic                  esc, zr_fits, zi_fits;

  // Squares and cross product rescaled to the fixed-point grid, kept at full width
  assign rr_full = PW'(zr_q) * PW'(zr_q);
  assign ii_full = PW'(zi_q) * PW'(zi_q);
  assign ri_full = PW'(zr_q) * PW'(zi_q);
  assign rr      = rr_full >>> FRAC;
  assign ii      = ii_full >>> FRAC;
  assign ri      = ri_full >>> FRAC;

  // A pending overflow from the previous update is reported as an escape
  assign mag = (PW+1)'(rr) + (PW+1)'(ii);
  assign esc = ovf_q | (mag > ESC_LIM);

  // Update sums are formed wide; a sum that does not fit W signed bits flags overflow
  assign zr_sum  = (PW+2)'(rr) - (PW+2)'(ii) + (PW+2)'(cr_q);
  assign zi_sum  = (PW+2)'(ri) + (PW+2)'(ri) + (PW+2)'(ci_q);
  assign zr_top  = zr_sum[PW+1:W-1];
  assign zi_top  = zi_sum[PW+1:W-1];
  assign zr_fits = (&zr_top) | ~(|zr_top);
  assign zi_fits = (&zi_top) | ~(|zi_top);

  assign eng.in_ready   = (state_q == S_IDLE);
  assign eng.out_valid  = (state_q == S_DONE);
  assign eng.busy       = (state_q != S_IDLE);
  assign eng.iter_count = iter_count_q;
  assign eng.escaped    = escaped_q;
  assign eng.x_out      = x_out_q;
  assign eng.y_out      = y_out_q;

  // Next-state and datapath updates for the IDLE / ITERATE / DONE sequence
  always_comb begin
    state_d      = state_q;
    zr_d         = zr_q;
    zi_d         = zi_q;
    cr_d         = cr_q;
    ci_d         = ci_q;
    n_d          = n_q;
    limit_d      = limit_q;
    ovf_d        = ovf_q;
    x_d          = x_q;
    y_d          = y_q;
    iter_count_d = iter_count_q;
    escaped_d    = escaped_q;
    x_out_d      = x_out_q;
    y_out_d      = y_out_q;
    case (state_q)
      S_IDLE: begin
        if (eng.in_valid) begin
          cr_d    = eng.c_real;
          ci_d    = eng.c_imag;
          x_d     = eng.x_in;
          y_d     = eng.y_in;
          limit_d = eng.max_iter;
          zr_d    = '0;
          zi_d    = '0;
          n_d     = '0;
          ovf_d   = 1'b0;
          state_d = S_ITERATE;
        end
      end
      S_ITERATE: begin
        if (esc || (n_q == limit_q)) begin
          escaped_d    = esc;
          iter_count_d = n_q;
          x_out_d      = x_q;
          y_out_d      = y_q;
          state_d      = S_DONE;
        end else begin
          zr_d = zr_sum[W-1:0];
          zi_d = zi_sum[W-1:0];
          n_d  = n_q + ITER_WIDTH'(1);
          if (!zr_fits || !zi_fits) begin
            ovf_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (eng.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any point in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      zr_q         <= '0;
      zi_q         <= '0;
      cr_q         <= '0;
      ci_q         <= '0;
      n_q          <= '0;
      limit_q      <= '0;
      ovf_q        <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      iter_count_q <= '0;
      escaped_q    <= 1'b0;
      x_out_q      <= '0;
      y_out_q      <= '0;
    end else begin
      state_q      <= state_d;
      zr_q         <= zr_d;
      zi_q         <= zi_d;
      cr_q         <= cr_d;
      ci_q         <= ci_d;
      n_q          <= n_d;
      limit_q      <= limit_d;
      ovf_q        <= ovf_d;
      x_q          <= x_d;
      y_q          <= y_d;
      iter_count_q <= iter_count_d;
      escaped_q    <= escaped_d;
      x_out_q      <= x_out_d;
      y_out_q      <= y_out_d;
    end
  end
endmodule
